// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one request/response channel.
// master = requester (core LSU or debug loader), slave = arbiter.
interface dmem_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, addr, write, size, is_unsigned, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, addr, write, size, is_unsigned, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto a single-port data memory: lane steering, load extension, 1-cycle response.
// Optional macro DMEM_ARB_ALIGN_CHECK_EN: misaligned half/word accesses are suppressed and flagged via err.
module dmem_arbiter #(
    parameter int DATA_BITS      = 16,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    dmem_arbiter_if.slave        rq0,
    dmem_arbiter_if.slave        rq1,
    output logic [DATA_BITS-3:0] mem_address,
    output logic [3:0]           mem_byteena,
    output logic [31:0]          mem_data,
    output logic                 mem_wren,
    input  logic [31:0]          mem_q
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic        r_last_grant;
    logic [1:0]  w_valid;
    logic [1:0]  w_gnt;
    logic        w_hs;
    logic        w_sel;

    logic [31:0] w_addr;
    logic        w_write;
    logic [1:0]  w_size;
    logic        w_unsigned;
    logic [31:0] w_wdata;
    logic        w_misalign;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_rdata_next;

    logic [1:0]        w_rvalid;
    logic [1:0][31:0]  w_rdata;
    logic [1:0]        w_err;

    logic [31-DATA_BITS:0] w_unused_addr_hi;

    assign w_valid = {rq1.valid, rq0.valid};

    // r_last_grant = 1 means port 1 was served last, so port 0 wins the next tie.
    always_comb begin
        w_gnt = 2'b00;
        if (reset_n) begin
            if (w_valid == 2'b11) begin
                if (FIXED_PRIORITY != 0 || r_last_grant)
                    w_gnt = 2'b01;
                else
                    w_gnt = 2'b10;
            end else begin
                w_gnt = w_valid;
            end
        end
    end

    assign w_hs      = |w_gnt;
    assign w_sel     = w_gnt[1];
    assign rq0.ready = w_gnt[0];
    assign rq1.ready = w_gnt[1];

    assign w_addr     = w_sel ? rq1.addr        : rq0.addr;
    assign w_write    = w_sel ? rq1.write       : rq0.write;
    assign w_size     = w_sel ? rq1.size        : rq0.size;
    assign w_unsigned = w_sel ? rq1.is_unsigned : rq0.is_unsigned;
    assign w_wdata    = w_sel ? rq1.wdata       : rq0.wdata;

    // Upper address bits alias onto the memory; they are deliberately dropped.
    assign w_unused_addr_hi = w_addr[31:DATA_BITS];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (w_size == SZ_HALF)
            w_misalign = w_addr[0];
        else if (w_size != SZ_BYTE)
            w_misalign = (w_addr[1:0] != 2'b00);
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign mem_address = w_addr[DATA_BITS-1:2];
    assign mem_wren    = w_hs && w_write && !w_misalign;

    always_comb begin
        mem_byteena = 4'b0000;
        mem_data    = w_wdata;
        case (w_size)
            SZ_BYTE: begin
                mem_byteena = 4'b0001 << w_addr[1:0];
                mem_data    = {4{w_wdata[7:0]}};
            end
            SZ_HALF: begin
                mem_byteena = w_addr[1] ? 4'b1100 : 4'b0011;
                mem_data    = {2{w_wdata[15:0]}};
            end
            default: begin
                mem_byteena = 4'b1111;
                mem_data    = w_wdata;
            end
        endcase
        if (!w_hs || w_misalign)
            mem_byteena = 4'b0000;
    end

    assign w_byte = mem_q[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_q[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = mem_q;
        case (w_size)
            SZ_BYTE: w_load_ext = w_unsigned ? {24'h000000, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load_ext = w_unsigned ? {16'h0000, w_half}
                                             : {{16{w_half[15]}}, w_half};
            default: w_load_ext = mem_q;
        endcase
    end

    assign w_rdata_next = (w_write || w_misalign) ? 32'h0000_0000 : w_load_ext;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_last_grant <= 1'b1;
        else if (w_hs)
            r_last_grant <= w_sel;
    end

    // One response register set per port; rdata/err hold between pulses.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            logic        r_rvalid;
            logic [31:0] r_rdata;
            logic        r_err;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= 32'h0000_0000;
                    r_err    <= 1'b0;
                end else begin
                    r_rvalid <= w_gnt[gi];
                    if (w_gnt[gi]) begin
                        r_rdata <= w_rdata_next;
                        r_err   <= w_misalign;
                    end
                end
            end

            assign w_rvalid[gi] = r_rvalid;
            assign w_rdata[gi]  = r_rdata;
            assign w_err[gi]    = r_err;
        end
    endgenerate

    assign rq0.rvalid = w_rvalid[0];
    assign rq0.rdata  = w_rdata[0];
    assign rq0.err    = w_err[0];
    assign rq1.rvalid = w_rvalid[1];
    assign rq1.rdata  = w_rdata[1];
    assign rq1.err    = w_err[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance with a memory model, plus a fixed-priority instance.
// Expectations follow DMEM_ARB_ALIGN_CHECK_EN when the macro is defined for the build.
module tb_dmem_arbiter;

    logic clock;
    logic reset_n;

    dmem_arbiter_if rq0_a ();
    dmem_arbiter_if rq1_a ();
    dmem_arbiter_if rq0_b ();
    dmem_arbiter_if rq1_b ();

    logic [13:0] mem_address_a, mem_address_b;
    logic [3:0]  mem_byteena_a, mem_byteena_b;
    logic [31:0] mem_data_a, mem_data_b;
    logic        mem_wren_a, mem_wren_b;
    logic [31:0] mem_q_a, mem_q_b;

    logic [31:0] mem_a [0:16383];

    int n_checks;
    int n_fail;

    dmem_arbiter #(.DATA_BITS(16), .FIXED_PRIORITY(0)) u_dut_rr (
        .clock       (clock),
        .reset_n     (reset_n),
        .rq0         (rq0_a),
        .rq1         (rq1_a),
        .mem_address (mem_address_a),
        .mem_byteena (mem_byteena_a),
        .mem_data    (mem_data_a),
        .mem_wren    (mem_wren_a),
        .mem_q       (mem_q_a)
    );

    dmem_arbiter #(.DATA_BITS(16), .FIXED_PRIORITY(1)) u_dut_fp (
        .clock       (clock),
        .reset_n     (reset_n),
        .rq0         (rq0_b),
        .rq1         (rq1_b),
        .mem_address (mem_address_b),
        .mem_byteena (mem_byteena_b),
        .mem_data    (mem_data_b),
        .mem_wren    (mem_wren_b),
        .mem_q       (mem_q_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_q_a = mem_a[mem_address_a];
    assign mem_q_b = 32'h0000_0000;

    always @(posedge clock) begin
        if (mem_wren_a) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteena_a[b])
                    mem_a[mem_address_a][8*b +: 8] <= mem_data_a[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        rq0_a.valid = 1'b0;
        rq1_a.valid = 1'b0;
        rq0_b.valid = 1'b0;
        rq1_b.valid = 1'b0;
    endtask

    task automatic drive(input int port, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (port == 0) begin
            rq0_a.valid = 1'b1; rq0_a.write = wr; rq0_a.size = sz;
            rq0_a.is_unsigned = uns; rq0_a.addr = addr; rq0_a.wdata = wd;
        end else begin
            rq1_a.valid = 1'b1; rq1_a.write = wr; rq1_a.size = sz;
            rq1_a.is_unsigned = uns; rq1_a.addr = addr; rq1_a.wdata = wd;
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next rising edge.
    task automatic xact(input string tag, input int port, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic exp_wren, input logic [31:0] exp_mdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] got_rv, got_oth, got_rd, got_err;
        clear_reqs();
        drive(port, wr, sz, uns, addr, wd);
        #2;
        check_eq({tag, ".ready"}, {31'b0, (port == 0) ? rq0_a.ready : rq1_a.ready}, 32'd1);
        check_eq({tag, ".byteena"}, {28'b0, mem_byteena_a}, {28'b0, exp_be});
        check_eq({tag, ".wren"}, {31'b0, mem_wren_a}, {31'b0, exp_wren});
        check_eq({tag, ".maddr"}, {18'b0, mem_address_a}, {18'b0, addr[15:2]});
        if (exp_wren)
            check_eq({tag, ".mdata"}, mem_data_a, exp_mdata);
        @(posedge clock);
        #1;
        clear_reqs();
        got_rv  = {31'b0, (port == 0) ? rq0_a.rvalid : rq1_a.rvalid};
        got_oth = {31'b0, (port == 0) ? rq1_a.rvalid : rq0_a.rvalid};
        got_rd  = (port == 0) ? rq0_a.rdata : rq1_a.rdata;
        got_err = {31'b0, (port == 0) ? rq0_a.err : rq1_a.err};
        check_eq({tag, ".rvalid"}, got_rv, 32'd1);
        check_eq({tag, ".other_rvalid"}, got_oth, 32'd0);
        check_eq({tag, ".rdata"}, got_rd, exp_rdata);
        check_eq({tag, ".err"}, got_err, {31'b0, exp_err});
        $display("XACT %-14s port=%0d wr=%0d size=%0d addr=%08h rdata=%08h err=%0d",
                 tag, port, wr, sz, addr, got_rd, got_err[0]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16384; i++) mem_a[i] = 32'h0000_0000;
        rq0_a.addr = '0; rq0_a.write = 0; rq0_a.size = 2'b10; rq0_a.is_unsigned = 0; rq0_a.wdata = '0;
        rq1_a.addr = '0; rq1_a.write = 0; rq1_a.size = 2'b10; rq1_a.is_unsigned = 0; rq1_a.wdata = '0;
        rq0_b.addr = 32'h10; rq0_b.write = 0; rq0_b.size = 2'b10; rq0_b.is_unsigned = 0; rq0_b.wdata = '0;
        rq1_b.addr = 32'h10; rq1_b.write = 0; rq1_b.size = 2'b10; rq1_b.is_unsigned = 0; rq1_b.wdata = '0;
        clear_reqs();
        reset_n = 1'b0;

        // Reset state: outputs cleared, request refused, no memory write.
        #2;
        drive(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h5555_5555);
        #1;
        check_eq("rst.ready0", {31'b0, rq0_a.ready}, 32'd0);
        check_eq("rst.wren", {31'b0, mem_wren_a}, 32'd0);
        check_eq("rst.rvalid0", {31'b0, rq0_a.rvalid}, 32'd0);
        check_eq("rst.rdata0", rq0_a.rdata, 32'd0);
        check_eq("rst.err0", {31'b0, rq0_a.err}, 32'd0);
        $display("XACT reset         ready0=%0d rvalid0=%0d", rq0_a.ready, rq0_a.rvalid);
        clear_reqs();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // tag, port, wr, size, uns, addr, wdata, be, wren, mdata, rdata, err
        xact("st_w_10",   0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'hDEADBEEF, 32'h0, 0);
        xact("ld_w_10",   0, 0, 2'b10, 0, 32'h10, 32'h0,        4'hF, 0, 32'h0,        32'hDEADBEEF, 0);
        @(posedge clock);
        #1;
        check_eq("idle.rvalid0", {31'b0, rq0_a.rvalid}, 32'd0);
        check_eq("idle.rdata0_hold", rq0_a.rdata, 32'hDEADBEEF);
        check_eq("idle.byteena", {28'b0, mem_byteena_a}, 32'd0);
        $display("XACT idle          rvalid0=%0d rdata0=%08h", rq0_a.rvalid, rq0_a.rdata);

        xact("st_b_13",   0, 1, 2'b00, 0, 32'h13, 32'h0000_0080, 4'h8, 1, 32'h80808080, 32'h0, 0);
        xact("ld_bs_13",  0, 0, 2'b00, 0, 32'h13, 32'h0,         4'h8, 0, 32'h0, 32'hFFFFFF80, 0);
        xact("ld_bu_13",  0, 0, 2'b00, 1, 32'h13, 32'h0,         4'h8, 0, 32'h0, 32'h00000080, 0);
        xact("st_w_14",   0, 1, 2'b10, 0, 32'h14, 32'hCAFE5678,  4'hF, 1, 32'hCAFE5678, 32'h0, 0);
        xact("st_h_16",   0, 1, 2'b01, 0, 32'h16, 32'h0000_1234, 4'hC, 1, 32'h12341234, 32'h0, 0);
        xact("ld_w_14",   0, 0, 2'b10, 0, 32'h14, 32'h0,         4'hF, 0, 32'h0, 32'h12345678, 0);
        xact("p1_st_h_16",1, 1, 2'b01, 0, 32'h16, 32'h0000_8001, 4'hC, 1, 32'h80018001, 32'h0, 0);
        xact("ld_hs_16",  0, 0, 2'b01, 0, 32'h16, 32'h0,         4'hC, 0, 32'h0, 32'hFFFF8001, 0);
        xact("ld_hu_14",  0, 0, 2'b01, 1, 32'h14, 32'h0,         4'h3, 0, 32'h0, 32'h00005678, 0);
        xact("p1_ld_bs_11",1,0, 2'b00, 0, 32'h11, 32'h0,         4'h2, 0, 32'h0, 32'hFFFFFFBE, 0);
        xact("p1_ld_hu_12",1,0, 2'b01, 1, 32'h12, 32'h0,         4'hC, 0, 32'h0, 32'h000080AD, 0);

        // Contention: last winner was port 1, so port 0 goes first on the round-robin instance.
        for (int k = 0; k < 4; k++) begin
            clear_reqs();
            drive(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
            drive(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
            rq0_b.valid = 1'b1;
            rq1_b.valid = 1'b1;
            #2;
            check_eq($sformatf("rr%0d.ready0", k), {31'b0, rq0_a.ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("rr%0d.ready1", k), {31'b0, rq1_a.ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("fp%0d.ready0", k), {31'b0, rq0_b.ready}, 32'd1);
            check_eq($sformatf("fp%0d.ready1", k), {31'b0, rq1_b.ready}, 32'd0);
            @(posedge clock);
            #1;
            check_eq($sformatf("rr%0d.rvalid0", k), {31'b0, rq0_a.rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("rr%0d.rvalid1", k), {31'b0, rq1_a.rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("rr%0d.rdata", k), (k % 2 == 0) ? rq0_a.rdata : rq1_a.rdata, 32'h80015678);
            check_eq($sformatf("fp%0d.rvalid0", k), {31'b0, rq0_b.rvalid}, 32'd1);
            check_eq($sformatf("fp%0d.rvalid1", k), {31'b0, rq1_b.rvalid}, 32'd0);
            $display("XACT contend%0d     rr_rv=%0d%0d fp_rv=%0d%0d", k,
                     rq1_a.rvalid, rq0_a.rvalid, rq1_b.rvalid, rq0_b.rvalid);
        end
        clear_reqs();

        // Alignment handling.
        xact("st_w_00",   0, 1, 2'b10, 0, 32'h00, 32'h11223344, 4'hF, 1, 32'h11223344, 32'h0, 0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        xact("st_w_02_mis", 0, 1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 32'h0, 1);
        xact("ld_w_02_mis", 0, 0, 2'b10, 0, 32'h02, 32'h0,        4'h0, 0, 32'h0, 32'h0, 1);
        xact("ld_w_00",     0, 0, 2'b10, 0, 32'h00, 32'h0,        4'hF, 0, 32'h0, 32'h11223344, 0);
        xact("ld_h_01_mis", 0, 0, 2'b01, 0, 32'h01, 32'h0,        4'h0, 0, 32'h0, 32'h0, 1);
`else
        xact("st_w_02_mis", 0, 1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 4'hF, 1, 32'hFFFFFFFF, 32'h0, 0);
        xact("ld_w_02_mis", 0, 0, 2'b10, 0, 32'h02, 32'h0,        4'hF, 0, 32'h0, 32'hFFFFFFFF, 0);
        xact("ld_w_00",     0, 0, 2'b10, 0, 32'h00, 32'h0,        4'hF, 0, 32'h0, 32'hFFFFFFFF, 0);
        xact("ld_h_01_mis", 0, 0, 2'b01, 0, 32'h01, 32'h0,        4'h3, 0, 32'h0, 32'hFFFFFFFF, 0);
`endif
        xact("ld_w_10b",  0, 0, 2'b10, 0, 32'h10, 32'h0, 4'hF, 0, 32'h0, 32'h80ADBEEF, 0);

        // Reset lands between handshake and response: the response is dropped.
        clear_reqs();
        drive(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid.ready0", {31'b0, rq0_a.ready}, 32'd0);
        check_eq("rstmid.wren", {31'b0, mem_wren_a}, 32'd0);
        @(posedge clock);
        #1;
        check_eq("rstmid.rvalid0", {31'b0, rq0_a.rvalid}, 32'd0);
        check_eq("rstmid.rdata0", rq0_a.rdata, 32'd0);
        $display("XACT reset_mid     rvalid0=%0d rdata0=%08h", rq0_a.rvalid, rq0_a.rdata);
        clear_reqs();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        drive(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        #2;
        check_eq("post_rst.ready0", {31'b0, rq0_a.ready}, 32'd1);
        check_eq("post_rst.ready1", {31'b0, rq1_a.ready}, 32'd0);
        @(posedge clock);
        #1;
        check_eq("post_rst.rvalid0", {31'b0, rq0_a.rvalid}, 32'd1);
        check_eq("post_rst.rvalid1", {31'b0, rq1_a.rvalid}, 32'd0);
        check_eq("post_rst.rdata0", rq0_a.rdata, 32'h80ADBEEF);
        $display("XACT post_reset    rvalid0=%0d rvalid1=%0d", rq0_a.rvalid, rq1_a.rvalid);
        clear_reqs();
        @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
